t_to_multi_ff_bank: RTL and testbench

- WIDTH-bit register bank whose storage elements are T flip-flops only.
- Per-bit excitation logic converts SR, JK, D or T drive into the T input, selected by a bank-wide mode.
- Monitors forbidden SR drive (S=R=1), holds state on it, and counts occurrences.
- Serves as the general-purpose "any flip-flop from T" building block alongside the existing T-from-SR conversion cells.

---
 rtl/t_ff_conv_pkg.sv | 23 ++
 rtl/t_ff_cell.sv | 17 +
 rtl/t_to_multi_ff_bank.sv | 81 ++++++++
 tb/tb_t_to_multi_ff_bank.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/t_ff_conv_pkg.sv
// rtl/t_ff_conv_pkg.sv - mode constants and per-bit T excitation for the T-based flip-flop bank
package t_ff_conv_pkg;

    localparam logic [1:0] MODE_SR = 2'd0;
    localparam logic [1:0] MODE_JK = 2'd1;
    localparam logic [1:0] MODE_D  = 2'd2;
    localparam logic [1:0] MODE_T  = 2'd3;

    // SR with S=R=1 is forbidden; the bit holds instead of toggling as JK would.
    function automatic logic t_from(input logic [1:0] mode, input logic a,
                                    input logic b, input logic q);
        logic t;
        t = 1'b0;
        case (mode)
            MODE_SR: t = (a & b) ? 1'b0 : ((a & ~q) | (b & q));
            MODE_JK: t = (a & ~q) | (b & q);
            MODE_D:  t = a ^ q;
            default: t = a;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - single T flip-flop with asynchronous active-high reset
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_to_multi_ff_bank.sv
// rtl/t_to_multi_ff_bank.sv - T flip-flop bank emulating SR/JK/D/T with forbidden-drive monitor
module t_to_multi_ff_bank
    import t_ff_conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             illegal,
    output logic [WIDTH-1:0] illegal_mask,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             illegal_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] mask_next;
    logic             any_illegal;

    always_comb begin
        t         = '0;
        mask_next = '0;
        if (load_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                t[i] = t_from(mode, a[i], b[i], q[i]);
            end
            if (mode == MODE_SR) begin
                mask_next = a & b;
            end
        end
    end

    assign any_illegal = |mask_next;
    assign qb          = ~q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal      <= 1'b0;
            illegal_mask <= '0;
        end else begin
            illegal      <= any_illegal;
            illegal_mask <= mask_next;
        end
    end

    // err_clr wins over a coincident event; illegal/illegal_mask still report it above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt    <= '0;
            illegal_sticky <= 1'b0;
        end else if (err_clr) begin
            illegal_cnt    <= '0;
            illegal_sticky <= 1'b0;
        end else begin
            if (any_illegal && (illegal_cnt != CNT_MAX)) begin
                illegal_cnt <= illegal_cnt + CNT_ONE;
            end
            illegal_sticky <= illegal_sticky | any_illegal;
        end
    end

endmodule

// File: tb/tb_t_to_multi_ff_bank.sv
// tb/tb_t_to_multi_ff_bank.sv - scoreboard bench for the T-based flip-flop bank
module tb_t_to_multi_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [1:0] mode0 = 2'd0, mode1 = 2'd0;
    logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
    logic       le0 = 1'b0, clr0 = 1'b0, le1 = 1'b0, clr1 = 1'b0;

    logic [7:0] q0, qb0, mask0, cnt0;
    logic       ill0, st0;
    logic [7:0] q1, qb1, mask1;
    logic [1:0] cnt1;
    logic       ill1, st1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         dut;
        logic [7:0] q;
        logic       ill;
        logic [7:0] mask;
        logic [7:0] cnt;
        logic       sticky;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    t_to_multi_ff_bank #(.WIDTH(8), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .mode(mode0), .a(a0), .b(b0),
        .load_en(le0), .err_clr(clr0), .q(q0), .qb(qb0),
        .illegal(ill0), .illegal_mask(mask0), .illegal_cnt(cnt0),
        .illegal_sticky(st0)
    );

    t_to_multi_ff_bank #(.WIDTH(8), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .a(a1), .b(b1),
        .load_en(le1), .err_clr(clr1), .q(q1), .qb(qb1),
        .illegal(ill1), .illegal_mask(mask1), .illegal_cnt(cnt1),
        .illegal_sticky(st1)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives must be known whenever the bank is loading.
    always @(posedge clk) begin
        if (!rst && le0 && $isunknown({mode0, a0, b0})) begin
            errors++;
            $display("FAIL xcheck dut0: unknown drive while load_en=1");
        end
        if (!rst && le1 && $isunknown({mode1, a1, b1})) begin
            errors++;
            $display("FAIL xcheck dut1: unknown drive while load_en=1");
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                chk({e.name, " q"},      q0, e.q);
                chk({e.name, " qb"},     qb0, ~e.q);
                chk({e.name, " ill"},    {7'd0, ill0}, {7'd0, e.ill});
                chk({e.name, " mask"},   mask0, e.mask);
                chk({e.name, " cnt"},    cnt0, e.cnt);
                chk({e.name, " sticky"}, {7'd0, st0}, {7'd0, e.sticky});
            end else begin
                chk({e.name, " q"},      q1, e.q);
                chk({e.name, " ill"},    {7'd0, ill1}, {7'd0, e.ill});
                chk({e.name, " mask"},   mask1, e.mask);
                chk({e.name, " cnt"},    {6'd0, cnt1}, e.cnt);
                chk({e.name, " sticky"}, {7'd0, st1}, {7'd0, e.sticky});
            end
        end
    end

    task automatic drive(input int d, input logic [1:0] m, input logic [7:0] av,
                         input logic [7:0] bv, input logic le, input logic clr,
                         input logic [7:0] eq, input logic eill, input logic [7:0] emask,
                         input logic [7:0] ecnt, input logic est, input string nm);
        exp_t e;
        @(negedge clk);
        if (d == 0) begin
            mode0 = m; a0 = av; b0 = bv; le0 = le; clr0 = clr;
            le1 = 1'b0; clr1 = 1'b0;
        end else begin
            mode1 = m; a1 = av; b1 = bv; le1 = le; clr1 = clr;
            le0 = 1'b0; clr0 = 1'b0;
        end
        e.dut = d; e.q = eq; e.ill = eill; e.mask = emask;
        e.cnt = ecnt; e.sticky = est; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        le0 = 1'b0; clr0 = 1'b0; le1 = 1'b0; clr1 = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Build q=A5 with a pending illegal event, then reset asynchronously.
        drive(0, 2'd2, 8'hA5, 8'h00, 1, 0, 8'hA5, 0, 8'h00, 8'd0, 0, "pre_d");
        drive(0, 2'd0, 8'h01, 8'h01, 1, 0, 8'hA5, 1, 8'h01, 8'd1, 1, "pre_sr");
        drain();
        #2 rst = 1'b1;
        #1;
        chk("rst q",      q0, 8'h00);
        chk("rst ill",    {7'd0, ill0}, 8'h00);
        chk("rst mask",   mask0, 8'h00);
        chk("rst cnt",    cnt0, 8'h00);
        chk("rst sticky", {7'd0, st0}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        drive(0, 2'd0, 8'h0F, 8'h00, 1, 0, 8'h0F, 0, 8'h00, 8'd0, 0, "sr_set");
        drive(0, 2'd0, 8'h00, 8'h03, 1, 0, 8'h0C, 0, 8'h00, 8'd0, 0, "sr_rst");
        drive(0, 2'd0, 8'h81, 8'h81, 1, 0, 8'h0C, 1, 8'h81, 8'd1, 1, "sr_bad");
        drive(0, 2'd1, 8'hFF, 8'hFF, 1, 0, 8'hF3, 0, 8'h00, 8'd1, 1, "jk_tog1");
        drive(0, 2'd1, 8'hFF, 8'hFF, 1, 0, 8'h0C, 0, 8'h00, 8'd1, 1, "jk_tog2");
        drive(0, 2'd0, 8'hFF, 8'hFF, 0, 0, 8'h0C, 0, 8'h00, 8'd1, 1, "sr_noload");
        drive(0, 2'd2, 8'h5A, 8'h00, 1, 0, 8'h5A, 0, 8'h00, 8'd1, 1, "d_load");
        drive(0, 2'd2, 8'hFF, 8'h00, 0, 0, 8'h5A, 0, 8'h00, 8'd1, 1, "d_hold");
        drive(0, 2'd2, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'd1, 1, "d_zero");
        drive(0, 2'd3, 8'h01, 8'h00, 1, 0, 8'h01, 0, 8'h00, 8'd1, 1, "t_1");
        drive(0, 2'd3, 8'h01, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'd1, 1, "t_2");
        drive(0, 2'd3, 8'h01, 8'h00, 1, 0, 8'h01, 0, 8'h00, 8'd1, 1, "t_3");
        drive(0, 2'd3, 8'h01, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'd1, 1, "t_4");
        drive(0, 2'd0, 8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00, 8'd0, 0, "clr0");
        drain();

        drive(1, 2'd0, 8'h03, 8'h03, 1, 0, 8'h00, 1, 8'h03, 8'd1, 1, "sat_1");
        drive(1, 2'd0, 8'h03, 8'h03, 1, 0, 8'h00, 1, 8'h03, 8'd2, 1, "sat_2");
        drive(1, 2'd0, 8'h03, 8'h03, 1, 0, 8'h00, 1, 8'h03, 8'd3, 1, "sat_3");
        drive(1, 2'd0, 8'h03, 8'h03, 1, 0, 8'h00, 1, 8'h03, 8'd3, 1, "sat_4");
        drive(1, 2'd0, 8'h03, 8'h03, 1, 0, 8'h00, 1, 8'h03, 8'd3, 1, "sat_5");
        drive(1, 2'd0, 8'h03, 8'h03, 1, 1, 8'h00, 1, 8'h03, 8'd0, 0, "sat_clr");
        drive(1, 2'd0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'd0, 0, "sat_after");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
